// File: rtl/universal_shift_register_pkg.sv
// Shared definitions for the universal shift register: step mode codes and
// the burst controller state encoding.
package usr_pkg;

  localparam logic [1:0] MODE_SHL = 2'b00;
  localparam logic [1:0] MODE_SHR = 2'b01;
  localparam logic [1:0] MODE_ROL = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } usr_state_e;

endpackage

// File: rtl/universal_shift_register_if.sv
// Control/status bundle between the board switch/button logic and the
// universal shift register core.
interface universal_shift_register_if #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8
) ();

  logic              preset;
  logic              load;
  logic [WIDTH-1:0]  pdata;
  logic [1:0]        mode;
  logic              sin_lsb;
  logic              sin_msb;
  logic              run;
  logic              start;
  logic [STEP_W-1:0] steps;
  logic [WIDTH-1:0]  q;
  logic              sout_lsb;
  logic              sout_msb;
  logic              busy;
  logic              done;

  modport master (
    output preset, load, pdata, mode, sin_lsb, sin_msb, run, start, steps,
    input  q, sout_lsb, sout_msb, busy, done
  );

  modport slave (
    input  preset, load, pdata, mode, sin_lsb, sin_msb, run, start, steps,
    output q, sout_lsb, sout_msb, busy, done
  );

endinterface

// File: rtl/universal_shift_register_tick_prescaler.sv
// Free-running step-rate prescaler: tick is high in the cycle where the
// count reaches DIV-1; DIV=1 yields a tick every cycle.
module tick_prescaler #(
  parameter int unsigned DIV = 75000000
) (
  input  logic clk,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_r;

  // Wrapping 0..DIV-1 counter, only clear restarts it
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r == LAST) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign tick = (cnt_r == LAST);

endmodule

// File: rtl/universal_shift_register.sv
// N-bit universal shift register with prescaled step rate, free-run mode
// and counted bursts with a start/busy/done handshake.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DIV    = 75000000,
  parameter int STEP_W = 8
) (
  input  logic                        clk,
  input  logic                        clear,
  universal_shift_register_if.slave   bus
);

  logic              tick_s;
  usr_state_e        state_r, state_s;
  logic [WIDTH-1:0]  q_r, q_s;
  logic [STEP_W-1:0] rem_r, rem_s;
  logic [1:0]        lmode_r, lmode_s;
  logic              busy_r;
  logic              done_r, done_s;

  function automatic logic [WIDTH-1:0] step_fn(
    input logic [WIDTH-1:0] cur,
    input logic [1:0]       m,
    input logic             sl,
    input logic             sm
  );
    logic [WIDTH-1:0] nxt;
    case (m)
      MODE_SHL: nxt = {cur[WIDTH-2:0], sl};
      MODE_SHR: nxt = {sm, cur[WIDTH-1:1]};
      MODE_ROL: nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ROR: nxt = {cur[0], cur[WIDTH-1:1]};
      default:  nxt = cur;
    endcase
    return nxt;
  endfunction

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (clk),
    .clear (clear),
    .tick  (tick_s)
  );

  // Next-state and datapath: preset > load > burst/free-run step
  always_comb begin
    state_s = state_r;
    q_s     = q_r;
    rem_s   = rem_r;
    lmode_s = lmode_r;
    done_s  = 1'b0;
    if (bus.preset) begin
      // A preset or load also drops any burst request in the same cycle
      q_s     = {WIDTH{1'b1}};
      state_s = IDLE;
    end else if (bus.load) begin
      q_s     = bus.pdata;
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.run && tick_s) begin
            q_s = step_fn(q_r, bus.mode, bus.sin_lsb, bus.sin_msb);
          end else begin
            q_s = q_r;
          end
          if (bus.start) begin
            if (bus.steps != {STEP_W{1'b0}}) begin
              rem_s   = bus.steps;
              lmode_s = bus.mode;
              state_s = BURST;
            end else begin
              done_s  = 1'b1;
            end
          end else begin
            state_s = IDLE;
          end
        end
        BURST: begin
          if (tick_s) begin
            q_s   = step_fn(q_r, lmode_r, bus.sin_lsb, bus.sin_msb);
            rem_s = rem_r - STEP_W'(1);
            if (rem_r == STEP_W'(1)) begin
              state_s = IDLE;
              done_s  = 1'b1;
            end else begin
              state_s = BURST;
            end
          end else begin
            q_s = q_r;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clear) begin
      state_r <= IDLE;
      q_r     <= {WIDTH{1'b0}};
      rem_r   <= {STEP_W{1'b0}};
      lmode_r <= MODE_SHL;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      q_r     <= q_s;
      rem_r   <= rem_s;
      lmode_r <= lmode_s;
      busy_r  <= (state_s == BURST);
      done_r  <= done_s;
    end
  end

  assign bus.q        = q_r;
  assign bus.sout_lsb = q_r[0];
  assign bus.sout_msb = q_r[WIDTH-1];
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

endmodule

// File: tb/tb_universal_shift_register.sv
// Two DUTs (DIV=1 and DIV=3) driven in lockstep and compared every cycle
// against a behavioural model, plus directed checks of the key scenarios.
module tb_universal_shift_register;

  localparam int W = 4;
  localparam int SW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clear_v = 1'b1, preset_v = 1'b0, load_v = 1'b0;
  logic [W-1:0]  pdata_v = 4'h0;
  logic [1:0]    mode_v = 2'b00;
  logic          sl_v = 1'b0, sm_v = 1'b0, run_v = 1'b0, start_v = 1'b0;
  logic [SW-1:0] steps_v = 8'd0;

  universal_shift_register_if #(.WIDTH(W), .STEP_W(SW)) if1 ();
  universal_shift_register_if #(.WIDTH(W), .STEP_W(SW)) if3 ();

  assign if1.preset = preset_v;  assign if3.preset = preset_v;
  assign if1.load = load_v;      assign if3.load = load_v;
  assign if1.pdata = pdata_v;    assign if3.pdata = pdata_v;
  assign if1.mode = mode_v;      assign if3.mode = mode_v;
  assign if1.sin_lsb = sl_v;     assign if3.sin_lsb = sl_v;
  assign if1.sin_msb = sm_v;     assign if3.sin_msb = sm_v;
  assign if1.run = run_v;        assign if3.run = run_v;
  assign if1.start = start_v;    assign if3.start = start_v;
  assign if1.steps = steps_v;    assign if3.steps = steps_v;

  universal_shift_register #(.WIDTH(W), .DIV(1), .STEP_W(SW)) u_dut1 (
    .clk(clk), .clear(clear_v), .bus(if1));
  universal_shift_register #(.WIDTH(W), .DIV(3), .STEP_W(SW)) u_dut3 (
    .clk(clk), .clear(clear_v), .bus(if3));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, index 0 -> DIV=1, index 1 -> DIV=3
  int div_m[2] = '{1, 3};
  int cyc_m[2];
  int q_m[2];
  int rem_m[2];
  int lmode_m[2];
  bit busy_m[2];
  bit done_m[2];

  function automatic int model_step(int q, int m, bit sl, bit sm);
    int full;
    full = 2 ** W;
    case (m)
      0:       return (q * 2) % full + sl;
      1:       return q / 2 + sm * (full / 2);
      2:       return (q * 2) % full + q / (full / 2);
      default: return q / 2 + (q % 2) * (full / 2);
    endcase
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit tk;
      bit dn;
      dn = 1'b0;
      if (clear_v) begin
        q_m[i] = 0; busy_m[i] = 1'b0; cyc_m[i] = 0; rem_m[i] = 0; lmode_m[i] = 0;
      end else begin
        tk = ((cyc_m[i] % div_m[i]) == div_m[i] - 1);
        cyc_m[i]++;
        if (preset_v) begin
          q_m[i] = 2 ** W - 1; busy_m[i] = 1'b0;
        end else if (load_v) begin
          q_m[i] = int'(pdata_v); busy_m[i] = 1'b0;
        end else if (busy_m[i]) begin
          if (tk) begin
            q_m[i] = model_step(q_m[i], lmode_m[i], sl_v, sm_v);
            rem_m[i]--;
            if (rem_m[i] == 0) begin busy_m[i] = 1'b0; dn = 1'b1; end
          end
        end else begin
          if (run_v && tk) q_m[i] = model_step(q_m[i], int'(mode_v), sl_v, sm_v);
          if (start_v) begin
            if (steps_v != 8'd0) begin
              rem_m[i] = int'(steps_v); lmode_m[i] = int'(mode_v); busy_m[i] = 1'b1;
            end else begin
              dn = 1'b1;
            end
          end
        end
      end
      done_m[i] = dn;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("q_div1",    32'(if1.q),        32'(q_m[0]));
    check("busy_div1", 32'(if1.busy),     32'(busy_m[0]));
    check("done_div1", 32'(if1.done),     32'(done_m[0]));
    check("slsb_div1", 32'(if1.sout_lsb), 32'(q_m[0] % 2));
    check("smsb_div1", 32'(if1.sout_msb), 32'(q_m[0] / 8));
    check("q_div3",    32'(if3.q),        32'(q_m[1]));
    check("busy_div3", 32'(if3.busy),     32'(busy_m[1]));
    check("done_div3", 32'(if3.done),     32'(done_m[1]));
    check("slsb_div3", 32'(if3.sout_lsb), 32'(q_m[1] % 2));
    check("smsb_div3", 32'(if3.sout_msb), 32'(q_m[1] / 8));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  int busy_cnt;
  int done_cnt;

  initial begin
    // Reset with run held high
    clear_v = 1'b1; run_v = 1'b1; mode_v = 2'b00; sl_v = 1'b1;
    cycle(); cycle();
    check("rst_q", 32'(if3.q), 32'h0);
    check("rst_busy", 32'(if3.busy), 32'h0);
    check("rst_done", 32'(if3.done), 32'h0);

    // Free-run shift left: DIV=1 steps every cycle, DIV=3 first on 3rd cycle
    clear_v = 1'b0;
    cycle(); check("shl1_a", 32'(if1.q), 32'h1); check("div3_t1", 32'(if3.q), 32'h0);
    cycle(); check("shl1_b", 32'(if1.q), 32'h3); check("div3_t2", 32'(if3.q), 32'h0);
    cycle(); check("shl1_c", 32'(if1.q), 32'h7); check("div3_t3", 32'(if3.q), 32'h1);
    cycle(); check("shl1_d", 32'(if1.q), 32'hf); check("shl1_msb", 32'(if1.sout_msb), 32'h1);

    // Rotate left then right on the DIV=1 instance
    run_v = 1'b0; load_v = 1'b1; pdata_v = 4'b1001;
    cycle(); check("load", 32'(if1.q), 32'h9);
    load_v = 1'b0; run_v = 1'b1; mode_v = 2'b10;
    cycle(); check("rol", 32'(if1.q), 32'h3);
    mode_v = 2'b11;
    cycle(); check("ror_a", 32'(if1.q), 32'h9);
    cycle(); check("ror_b", 32'(if1.q), 32'hc);

    // Burst of 3 shift-right steps, started on a tick-aligned cycle of DIV=3
    run_v = 1'b0; load_v = 1'b1; pdata_v = 4'b1000;
    cycle();
    load_v = 1'b0;
    while ((cyc_m[1] % 3) != 2) cycle();
    start_v = 1'b1; steps_v = 8'd3; mode_v = 2'b01; sm_v = 1'b0;
    cycle();
    start_v = 1'b0;
    busy_cnt = if3.busy ? 1 : 0;
    done_cnt = 0;
    for (int k = 0; k < 14; k++) begin
      if (k == 2) begin start_v = 1'b1; mode_v = 2'b10; end
      if (k == 3) start_v = 1'b0;
      cycle();
      if (if3.busy) busy_cnt++;
      if (if3.done) done_cnt++;
    end
    check("burst_busy_cycles", 32'(busy_cnt), 32'd9);
    check("burst_done_pulses", 32'(done_cnt), 32'd1);
    check("burst_q", 32'(if3.q), 32'h1);

    // Zero-length burst: done pulse only
    start_v = 1'b1; steps_v = 8'd0;
    cycle(); start_v = 1'b0;
    check("zero_done", 32'(if3.done), 32'h1);
    check("zero_busy", 32'(if3.busy), 32'h0);
    check("zero_q", 32'(if3.q), 32'h1);
    cycle(); check("zero_done_off", 32'(if3.done), 32'h0);

    // clear in the middle of a burst
    start_v = 1'b1; steps_v = 8'd5; mode_v = 2'b00; sl_v = 1'b1;
    cycle(); start_v = 1'b0;
    cycle(); cycle();
    clear_v = 1'b1;
    cycle(); clear_v = 1'b0;
    check("clr_q", 32'(if3.q), 32'h0);
    check("clr_busy", 32'(if3.busy), 32'h0);
    for (int k = 0; k < 6; k++) cycle();

    // preset + load during a burst: preset wins, burst aborted silently
    start_v = 1'b1; steps_v = 8'd6;
    cycle(); start_v = 1'b0;
    cycle();
    preset_v = 1'b1; load_v = 1'b1; pdata_v = 4'b0101;
    cycle(); preset_v = 1'b0; load_v = 1'b0;
    check("preset_q", 32'(if3.q), 32'hf);
    check("preset_busy", 32'(if3.busy), 32'h0);
    for (int k = 0; k < 8; k++) cycle();

    // Randomized operation against the model
    for (int k = 0; k < 600; k++) begin
      clear_v  = ($urandom_range(0, 99) < 2);
      preset_v = ($urandom_range(0, 99) < 3);
      load_v   = ($urandom_range(0, 99) < 5);
      pdata_v  = 4'($urandom);
      mode_v   = 2'($urandom);
      sl_v     = 1'($urandom);
      sm_v     = 1'($urandom);
      run_v    = 1'($urandom);
      start_v  = ($urandom_range(0, 99) < 20);
      steps_v  = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 6));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
